// File: rtl/set_assoc_cache_if.sv
// CPU-side and memory-side buses of set_assoc_cache, grouped so the cache and
// its environment connect through one interface instance.
interface set_assoc_cache_if #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WORDS = 2
);
    // cpu_req is sampled once while the cache is idle; cpu_ready pulses once per
    // accepted access. mem_req is held until a one-cycle mem_ack completes it.
    logic                         cpu_req;
    logic                         cpu_wren;
    logic [31:0]                  cpu_addr;
    logic [WIDTH-1:0]             cpu_din;
    logic                         cpu_ready;
    logic [WIDTH-1:0]             cpu_dout;
    logic                         mem_req;
    logic                         mem_we;
    logic [31:0]                  mem_addr;
    logic [BLOCK_WORDS*WIDTH-1:0] mem_wdata;
    logic                         mem_ack;
    logic [BLOCK_WORDS*WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_din, mem_ack, mem_rdata,
        output cpu_ready, cpu_dout, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_din, mem_ack, mem_rdata,
        input  cpu_ready, cpu_dout, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/set_assoc_cache.sv
// Blocking write-back, write-allocate set-associative cache with true-LRU
// replacement; one hit per cycle, misses go through WRITEBACK/FILL/RESPOND.
module set_assoc_cache #(
    parameter int NWAYS       = 2,
    parameter int NSETS       = 1024,
    parameter int BLOCK_WORDS = 2,
    parameter int WIDTH       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    set_assoc_cache_if.slave        bus,
    output logic [1:0]              dbg_state
);
    localparam int LINE_W = BLOCK_WORDS * WIDTH;
    localparam int OFF_W  = $clog2(BLOCK_WORDS * 4);
    localparam int IDX_W  = $clog2(NSETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WAY_W  = (NWAYS > 1) ? $clog2(NWAYS) : 1;
    localparam int WSEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [WAY_W-1:0] AGE_MAX = WAY_W'(NWAYS - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_FILL      = 2'd2,
        S_RESPOND   = 2'd3
    } state_t;

    logic [LINE_W-1:0] data_q  [NWAYS][NSETS];
    logic [TAG_W-1:0]  tag_q   [NWAYS][NSETS];
    logic              valid_q [NWAYS][NSETS];
    logic              dirty_q [NWAYS][NSETS];
    logic [WAY_W-1:0]  age_q   [NWAYS][NSETS];

    state_t            state_q, state_d;
    logic              req_wren_q, req_wren_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [WIDTH-1:0]  req_din_q, req_din_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [WIDTH-1:0]  cpu_dout_q, cpu_dout_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [31:0]       look_addr;
    logic [IDX_W-1:0]  look_idx;
    logic [TAG_W-1:0]  look_tag;
    logic [WSEL_W-1:0] look_word;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  victim_sel;
    logic [WAY_W-1:0]  max_age;
    logic              acc_en;
    logic [WAY_W-1:0]  acc_way;
    logic              acc_wr;
    logic [WIDTH-1:0]  acc_din;
    logic [WAY_W-1:0]  acc_age;
    logic              fill_en;

    // Idle lookups use the live CPU address; miss handling uses the captured one.
    always_comb begin
        look_addr = (state_q == S_IDLE) ? bus.cpu_addr : req_addr_q;
        look_idx  = look_addr[OFF_W +: IDX_W];
        look_tag  = look_addr[31 -: TAG_W];
        look_word = WSEL_W'(look_addr >> 2) & WSEL_W'(BLOCK_WORDS - 1);
    end

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        inv_found  = 1'b0;
        victim_sel = '0;
        max_age    = age_q[0][look_idx];
        for (int w = 0; w < NWAYS; w++) begin
            if (!hit && valid_q[w][look_idx] && tag_q[w][look_idx] == look_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        for (int w = 1; w < NWAYS; w++) begin
            if (age_q[w][look_idx] > max_age) begin
                max_age    = age_q[w][look_idx];
                victim_sel = WAY_W'(w);
            end
        end
        // An empty way always wins over the LRU way, lowest index first.
        for (int w = NWAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][look_idx]) begin
                inv_found  = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_wren_d  = req_wren_q;
        req_addr_d  = req_addr_q;
        req_din_d   = req_din_q;
        victim_d    = victim_q;
        cpu_ready_d = 1'b0;
        cpu_dout_d  = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        acc_en      = 1'b0;
        acc_way     = victim_q;
        acc_wr      = req_wren_q;
        acc_din     = req_din_q;
        fill_en     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    req_wren_d = bus.cpu_wren;
                    req_addr_d = bus.cpu_addr;
                    req_din_d  = bus.cpu_din;
                    if (hit) begin
                        acc_en      = 1'b1;
                        acc_way     = hit_way;
                        acc_wr      = bus.cpu_wren;
                        acc_din     = bus.cpu_din;
                        cpu_ready_d = 1'b1;
                        cpu_dout_d  = data_q[hit_way][look_idx][look_word*WIDTH +: WIDTH];
                    end else begin
                        victim_d  = victim_sel;
                        mem_req_d = 1'b1;
                        if (!inv_found && dirty_q[victim_sel][look_idx]) begin
                            state_d     = S_WRITEBACK;
                            mem_we_d    = 1'b1;
                            mem_addr_d  = {tag_q[victim_sel][look_idx], look_idx, OFF_W'(0)};
                            mem_wdata_d = data_q[victim_sel][look_idx];
                        end else begin
                            state_d    = S_FILL;
                            mem_we_d   = 1'b0;
                            mem_addr_d = {look_addr[31:OFF_W], OFF_W'(0)};
                        end
                    end
                end
            end
            S_WRITEBACK: begin
                if (bus.mem_ack) begin
                    state_d     = S_FILL;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                end
            end
            S_FILL: begin
                // Entering from WRITEBACK leaves one idle cycle before the fill request.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {req_addr_q[31:OFF_W], OFF_W'(0)};
                end else if (bus.mem_ack) begin
                    fill_en    = 1'b1;
                    state_d    = S_RESPOND;
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                end
            end
            S_RESPOND: begin
                acc_en      = 1'b1;
                acc_way     = victim_q;
                cpu_ready_d = 1'b1;
                cpu_dout_d  = data_q[victim_q][look_idx][look_word*WIDTH +: WIDTH];
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        acc_age = age_q[acc_way][look_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_wren_q  <= 1'b0;
            req_addr_q  <= '0;
            req_din_q   <= '0;
            victim_q    <= '0;
            cpu_ready_q <= 1'b0;
            cpu_dout_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_wren_q  <= req_wren_d;
            req_addr_q  <= req_addr_d;
            req_din_q   <= req_din_d;
            victim_q    <= victim_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_dout_q  <= cpu_dout_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Ranks: 0 is MRU. Ways ranked at or below the touched way age by one,
    // which also turns the all-zero reset ranks into a permutation as ways fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < NWAYS; w++) begin
                for (int s = 0; s < NSETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                    dirty_q[w][s] <= 1'b0;
                    age_q[w][s]   <= '0;
                end
            end
        end else begin
            if (fill_en) begin
                valid_q[victim_q][look_idx] <= 1'b1;
                dirty_q[victim_q][look_idx] <= 1'b0;
            end
            if (acc_en) begin
                if (acc_wr) dirty_q[acc_way][look_idx] <= 1'b1;
                if (NWAYS > 1) begin
                    for (int w = 0; w < NWAYS; w++) begin
                        if (WAY_W'(w) == acc_way) begin
                            age_q[w][look_idx] <= '0;
                        end else if (age_q[w][look_idx] <= acc_age && age_q[w][look_idx] != AGE_MAX) begin
                            age_q[w][look_idx] <= age_q[w][look_idx] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_en) begin
            data_q[victim_q][look_idx] <= bus.mem_rdata;
            tag_q[victim_q][look_idx]  <= look_tag;
        end
        if (!rst && acc_en && acc_wr) begin
            data_q[acc_way][look_idx][look_word*WIDTH +: WIDTH] <= acc_din;
        end
    end

    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_dout  = cpu_dout_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign dbg_state     = state_q;
endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 SHALL have parameter NWAYS, default 2, associativity; legal values 1, 2, 4.
REQ-002 SHALL have parameter NSETS, default 1024, sets per way; power of two.
REQ-003 SHALL have parameter BLOCK_WORDS, default 2, 32-bit words per line; legal values 1, 2, 4.
REQ-004 SHALL have parameter WIDTH, default 32, word width.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port cpu_req, input, 1, access request, sampled only in IDLE.
REQ-008 SHALL have port cpu_wren, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port cpu_addr, input, 32, byte address; bits [1:0] ignored.
REQ-010 SHALL have port cpu_din, input, WIDTH, store data.
REQ-011 SHALL have port cpu_ready, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port cpu_dout, output, WIDTH, load data, valid while cpu_ready=1.
REQ-013 SHALL have port mem_req, output, 1, memory request, held until mem_ack.
REQ-014 SHALL have port mem_we, output, 1, 1 = line writeback, 0 = line fill.
REQ-015 SHALL have port mem_addr, output, 32, line-aligned address; offset bits are zero.
REQ-016 SHALL have port mem_wdata, output, BLOCK_WORDS*WIDTH, writeback line; word 0 in the LSBs.
REQ-017 SHALL have port mem_ack, input, 1, one-cycle completion from memory.
REQ-018 SHALL have port mem_rdata, input, BLOCK_WORDS*WIDTH, fill line, valid with mem_ack.

Function
REQ-019 SHALL split cpu_addr into offset = log2(BLOCK_WORDS*4) LSBs, index = next log2(NSETS) bits, and tag = remaining MSBs.
REQ-020 SHALL keep per line a valid bit, a dirty bit, a tag and data, plus per-set true-LRU age ranks of log2(NWAYS) bits per way.
REQ-021 SHALL implement FSM states IDLE, WRITEBACK, FILL and RESPOND.
REQ-022 SHALL, in IDLE with cpu_req=1, capture wren, addr and din; the CPU need not hold them afterwards.
REQ-023 SHALL, on a hit in IDLE, pulse cpu_ready on the next cycle and stay in IDLE, sustaining one hit per cycle back to back.
REQ-024 SHALL, on a load hit, drive the addressed word on cpu_dout.
REQ-025 SHALL, on a store hit, write the addressed word and set dirty; cpu_dout is don't-care.
REQ-026 SHALL make any hit, and any RESPOND completion, the MRU way of its set.
REQ-027 SHALL, on a miss, choose as victim the lowest-index invalid way, else the LRU way.
REQ-028 SHALL go to WRITEBACK if the victim is valid and dirty, else to FILL.
REQ-029 SHALL, in WRITEBACK, hold mem_req=1, mem_we=1, mem_addr={victim tag, index, 0} and mem_wdata=victim line until mem_ack, then go to FILL.
REQ-030 SHALL, in FILL, hold mem_req=1, mem_we=0 and mem_addr=line-aligned request address until mem_ack.
REQ-031 SHALL, on the FILL mem_ack, install mem_rdata with valid=1, dirty=0 and the new tag, then go to RESPOND.
REQ-032 SHALL, in RESPOND, perform the captured load or store (write-allocate), pulse cpu_ready and return to IDLE.
REQ-033 SHALL drop mem_req in the cycle after mem_ack, with no back-to-back request in the same cycle.
REQ-034 SHALL ignore cpu_req in WRITEBACK, FILL and RESPOND.
REQ-035 SHALL hold cpu_ready=0 for the whole of any miss until the RESPOND pulse.
REQ-036 SHALL ignore mem_ack outside WRITEBACK and FILL.
REQ-037 SHALL support NWAYS=1 (direct-mapped) with the LRU state unused.

Reset
REQ-038 SHALL, with rst=1 at an edge, clear all valid, dirty and LRU state and enter IDLE; data and tag contents are don't-care.
REQ-039 SHALL, while rst=1 or after reset, drive cpu_ready=0, cpu_dout=0, mem_req=0, mem_we=0, mem_addr=0 and mem_wdata=0.
REQ-040 SHALL, on reset during WRITEBACK or FILL, abort the access: mem_req=0 on the next cycle, no cpu_ready pulse, and dirty data is discarded.
REQ-041 SHALL give rst priority over every other event in the same cycle.

Verification (NWAYS=2, NSETS=1024, BLOCK_WORDS=2: tag [31:13], index [12:3])
REQ-042 SHALL cover: reset, then load 0x10 -> FILL with mem_addr=0x10; ack with rdata 0x22222222_11111111 -> cpu_dout=0x11111111; then load 0x14 -> cpu_ready next cycle, dout=0x22222222, no mem_req.
REQ-043 SHALL cover: store 0xDEADBEEF at 0x10 (hit), load 0x2010 (fills way1), load 0x4010 -> WRITEBACK with mem_addr=0x10 and wdata=0x22222222_DEADBEEF, then FILL of 0x4010.
REQ-044 SHALL cover: mem_ack delayed 5 cycles with cpu_req toggling -> mem_req held 5 cycles, cpu_ready=0, no new request captured.
REQ-045 SHALL cover: rst pulsed during FILL -> mem_req=0 next cycle, and reloading the same address misses and refills.
REQ-046 SHALL cover: NWAYS=4, fill tags A,B,C,D into one set, load A, then miss on E -> B's way replaced; A hits.
REQ-047 SHALL cover: store miss to a clean full set -> FILL only (no WRITEBACK), merged word readable, and the line evicts dirty later.
